// File: rtl/prog_counter_pkg.sv
// Shared definitions for the program counter: default widths, FSM state
// encoding and the PC word type.
package prog_counter_pkg;

    localparam int unsigned D_DEFAULT  = 12;
    localparam int unsigned OW_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef logic [D_DEFAULT-1:0] pc_t;

endpackage

// File: rtl/prog_counter_next_sel.sv
// Combinational next-PC selection while running: Ret > Jump_abs > Br_rel > increment.
// Also exposes PC+1 so the top can capture the return address.
module pc_next_sel
    import prog_counter_pkg::*;
#(
    parameter int unsigned D  = D_DEFAULT,
    parameter int unsigned OW = OW_DEFAULT
) (
    input  logic [D-1:0]  pc,
    input  logic [D-1:0]  target,
    input  logic [D-1:0]  link,
    input  logic [OW-1:0] offset,
    input  logic          sel_ret,
    input  logic          sel_jump,
    input  logic          sel_br,
    output logic [D-1:0]  next_pc_c,
    output logic [D-1:0]  pc_inc_c
);

    logic [D-1:0] offset_ext;
    logic [D-1:0] pc_br;

    // Two's-complement offset widened to PC width; sums wrap modulo 2^D.
    assign offset_ext = D'($signed(offset));
    assign pc_br      = pc + offset_ext;
    assign pc_inc_c   = pc + D'(1);

    always_comb begin
        next_pc_c = pc_inc_c;
        if (sel_ret) begin
            next_pc_c = link;
        end else if (sel_jump) begin
            next_pc_c = target;
        end else if (sel_br) begin
            next_pc_c = pc_br;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Program counter with IDLE/RUN/HALTED control, stall, absolute jump with
// optional link, return and relative branch.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int unsigned D  = D_DEFAULT,
    parameter int unsigned OW = OW_DEFAULT
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Halt,
    input  logic          Stall,
    input  logic          Jump_abs,
    input  logic [D-1:0]  Target,
    input  logic          Link_en,
    input  logic          Ret,
    input  logic          Br_rel,
    input  logic [OW-1:0] Offset,
    output logic [D-1:0]  PC,
    output logic          Running,
    output logic          Done
);

    state_t       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic [D-1:0] link_q, link_d;
    logic         running_q, running_d;
    logic         done_q, done_d;
    logic [D-1:0] next_pc_c;
    logic [D-1:0] pc_inc_c;

    pc_next_sel #(
        .D  (D),
        .OW (OW)
    ) u_next_sel (
        .pc        (pc_q),
        .target    (Target),
        .link      (link_q),
        .offset    (Offset),
        .sel_ret   (Ret),
        .sel_jump  (Jump_abs),
        .sel_br    (Br_rel),
        .next_pc_c (next_pc_c),
        .pc_inc_c  (pc_inc_c)
    );

    // State, PC and link registers; reset overrides every input.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            link_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            link_q    <= link_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        link_d  = link_q;

        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (Start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Halt) begin
                    state_d = ST_HALTED;
                end else if (!Stall) begin
                    pc_d = next_pc_c;
                    // Link is captured only when the jump is the taken action.
                    if (!Ret && Jump_abs && Link_en) begin
                        link_d = pc_inc_c;
                    end
                end
            end
            ST_HALTED: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_HALTED);
    end

    assign PC      = pc_q;
    assign Running = running_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: stimulus pushes expected PC/Running/Done
// for each clock edge, a monitor pops and compares after the edge.
module tb_prog_counter;

    localparam int unsigned D  = 12;
    localparam int unsigned OW = 8;

    typedef struct {
        string        name;
        logic [D-1:0] pc;
        logic         running;
        logic         done;
    } exp_t;

    logic          Clk;
    logic          Reset, Start, Halt, Stall, Jump_abs, Link_en, Ret, Br_rel;
    logic [D-1:0]  Target;
    logic [OW-1:0] Offset;
    logic [D-1:0]  PC;
    logic          Running, Done;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    prog_counter #(.D(D), .OW(OW)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Halt     (Halt),
        .Stall    (Stall),
        .Jump_abs (Jump_abs),
        .Target   (Target),
        .Link_en  (Link_en),
        .Ret      (Ret),
        .Br_rel   (Br_rel),
        .Offset   (Offset),
        .PC       (PC),
        .Running  (Running),
        .Done     (Done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Drive one cycle of inputs at the falling edge and queue the expected result.
    task automatic step(input string nm,
                        input logic rst, input logic st, input logic hl, input logic sl,
                        input logic ja, input logic le, input logic rt, input logic br,
                        input logic [D-1:0] tgt, input logic [OW-1:0] off,
                        input logic [D-1:0] epc, input logic er, input logic ed);
        exp_t e;
        @(negedge Clk);
        Reset = rst; Start = st; Halt = hl; Stall = sl;
        Jump_abs = ja; Link_en = le; Ret = rt; Br_rel = br;
        Target = tgt; Offset = off;
        e.name = nm; e.pc = epc; e.running = er; e.done = ed;
        exp_q.push_back(e);
    endtask

    task automatic check(input string nm, input logic [D-1:0] act, input logic [D-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle, so compare after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".pc"},      PC,                e.pc);
                check({e.name, ".running"}, D'(Running),       D'(e.running));
                check({e.name, ".done"},    D'(Done),          D'(e.done));
            end
        end
    end

    initial begin
        bit drained;
        Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Stall = 1'b0;
        Jump_abs = 1'b0; Link_en = 1'b0; Ret = 1'b0; Br_rel = 1'b0;
        Target = '0; Offset = '0;

        //      name            rst st hl sl ja le rt br tgt   off    pc  run done
        step("reset",           1, 0, 0, 0, 0, 0, 0, 0, 0,    8'h00, 0,    0, 0);
        step("idle_ignore",     0, 0, 1, 0, 1, 1, 1, 1, 7,    8'h03, 0,    0, 0);
        step("start",           0, 1, 0, 0, 0, 0, 0, 0, 0,    8'h00, 0,    1, 0);
        for (int i = 1; i <= 5; i++)
            step("inc",         0, 0, 0, 0, 0, 0, 0, 0, 0,    8'h00, D'(i), 1, 0);

        step("reset2",          1, 0, 0, 0, 0, 0, 0, 0, 0,    8'h00, 0,    0, 0);
        step("start2",          0, 1, 0, 0, 0, 0, 0, 0, 0,    8'h00, 0,    1, 0);
        for (int i = 1; i <= 4; i++)
            step("inc2",        0, 0, 0, 0, 0, 0, 0, 0, 0,    8'h00, D'(i), 1, 0);
        step("br_neg5",         0, 0, 0, 0, 0, 0, 0, 1, 0,    8'hFB, 4095, 1, 0);
        step("wrap",            0, 0, 0, 0, 0, 0, 0, 0, 0,    8'h00, 0,    1, 0);

        step("jump10",          0, 0, 0, 0, 1, 0, 0, 0, 10,   8'h00, 10,   1, 0);
        step("jump_link45",     0, 0, 0, 0, 1, 1, 0, 0, 45,   8'h00, 45,   1, 0);
        step("inc46",           0, 0, 0, 0, 0, 0, 0, 0, 0,    8'h00, 46,   1, 0);
        step("link_only",       0, 0, 0, 0, 0, 1, 0, 0, 0,    8'h00, 47,   1, 0);
        step("ret11",           0, 0, 0, 0, 0, 0, 1, 0, 0,    8'h00, 11,   1, 0);
        step("ret_over_jump",   0, 0, 0, 0, 1, 1, 1, 0, 99,   8'h00, 11,   1, 0);

        step("jump20",          0, 0, 0, 0, 1, 0, 0, 0, 20,   8'h00, 20,   1, 0);
        for (int i = 0; i < 3; i++)
            step("stall_jump",  0, 0, 0, 1, 1, 1, 0, 0, 69,   8'h00, 20,   1, 0);
        step("jump69",          0, 0, 0, 0, 1, 0, 0, 0, 69,   8'h00, 69,   1, 0);
        step("br_pos16",        0, 0, 0, 0, 0, 0, 0, 1, 0,    8'h10, 85,   1, 0);
        step("jump_over_br",    0, 0, 0, 0, 1, 0, 0, 1, 80,   8'h05, 80,   1, 0);

        step("halt",            0, 0, 1, 0, 1, 0, 0, 0, 91,   8'h00, 80,   0, 1);
        for (int i = 0; i < 4; i++)
            step("halted_hold", 0, 0, 0, 0, 1, 0, 1, 1, 91,   8'h05, 80,   0, 1);
        step("restart",         0, 1, 0, 0, 0, 0, 0, 0, 0,    8'h00, 0,    1, 0);
        step("ret_link_kept",   0, 0, 0, 0, 0, 0, 1, 0, 0,    8'h00, 11,   1, 0);
        step("start_in_run",    0, 1, 0, 0, 0, 0, 0, 0, 0,    8'h00, 12,   1, 0);

        step("jump91",          0, 0, 0, 0, 1, 0, 0, 0, 91,   8'h00, 91,   1, 0);
        step("reset_in_run",    1, 0, 0, 0, 1, 1, 0, 0, 7,    8'h00, 0,    0, 0);
        step("start3",          0, 1, 0, 0, 0, 0, 0, 0, 0,    8'h00, 0,    1, 0);
        step("ret_link_zero",   0, 0, 0, 0, 0, 0, 1, 0, 0,    8'h00, 0,    1, 0);
        step("br_min",          0, 0, 0, 0, 0, 0, 0, 1, 0,    8'h80, 3968, 1, 0);
        step("br_max",          0, 0, 0, 0, 0, 0, 0, 1, 0,    8'h7F, 4095, 1, 0);
        step("halt2",           0, 0, 1, 0, 0, 0, 0, 0, 0,    8'h00, 4095, 0, 1);
        step("reset_halted",    1, 0, 0, 0, 0, 0, 0, 0, 0,    8'h00, 0,    0, 0);
        step("post_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0,    8'h00, 0,    0, 0);

        @(negedge Clk);
        Reset = 1'b0; Start = 1'b0; Halt = 1'b0; Stall = 1'b0;
        Jump_abs = 1'b0; Link_en = 1'b0; Ret = 1'b0; Br_rel = 1'b0;

        drained = 1'b0;
        for (int i = 0; i < 10 && !drained; i++) begin
            @(posedge Clk);
            #2;
            drained = (exp_q.size() == 0);
        end
        if (!drained) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 SHALL have parameter D, default 12, meaning PC/target width in bits.
REQ-002 SHALL have parameter OW, default 8, meaning relative-offset width in bits.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port Start, input, 1, begin execution from address 0.
REQ-006 SHALL have port Halt, input, 1, stop execution, assert Done.
REQ-007 SHALL have port Stall, input, 1, freeze PC and link register.
REQ-008 SHALL have port Jump_abs, input, 1, load PC from Target.
REQ-009 SHALL have port Target, input, D, absolute jump address from the branch-target lookup stage.
REQ-010 SHALL have port Link_en, input, 1, with Jump_abs, save return address.
REQ-011 SHALL have port Ret, input, 1, load PC from link register.
REQ-012 SHALL have port Br_rel, input, 1, take relative branch.
REQ-013 SHALL have port Offset, input, OW, two's-complement relative offset.
REQ-014 SHALL have port PC, output, D, current instruction address.
REQ-015 SHALL have port Running, output, 1, high in RUN state.
REQ-016 SHALL have port Done, output, 1, high in HALTED state.

Function
REQ-017 SHALL implement three states: IDLE, RUN, HALTED; PC, Running, Done registered.
REQ-018 IDLE: PC holds 0; Start=1 -> RUN next cycle with PC=0; all other inputs ignored.
REQ-019 RUN, priority per cycle: Halt > Stall > Ret > Jump_abs > Br_rel > increment.
REQ-020 Halt=1 in RUN -> HALTED next cycle; PC holds current value (no update that cycle).
REQ-021 Stall=1 (no Halt) -> PC and link register unchanged.
REQ-022 Ret -> PC <= link register; link register unchanged.
REQ-023 Jump_abs -> PC <= Target; if Link_en also 1, link <= (PC+1) mod 2^D in the same cycle.
REQ-024 Link_en without Jump_abs SHALL have no effect.
REQ-025 Br_rel -> PC <= (PC + sign-extended Offset) mod 2^D.
REQ-026 No control input -> PC <= (PC+1) mod 2^D; 2^D-1 wraps to 0 with no flag.
REQ-027 HALTED: PC and Done held; Start=1 -> RUN with PC=0, Done=0, link register preserved.
REQ-028 Start in RUN SHALL be ignored.
REQ-029 Target and Offset sampled only in the cycle their enable is taken.

Reset
REQ-030 Reset=1 at a clock edge SHALL force IDLE, PC=0, link=0, Running=0, Done=0, overriding all inputs in any state, mid-operation included.
REQ-031 First cycle after Reset deassertion SHALL be IDLE; Start is honoured from that cycle on.

Structure
REQ-032 Shared package SHALL hold D and OW defaults, the state enum (IDLE, RUN, HALTED), and the PC type logic [D-1:0].
REQ-033 Next-PC selection SHALL be a combinational sub-module pc_next_sel (inputs: PC, Target, link, Offset, selects; output: next PC); state register and link register stay in prog_counter.
REQ-034 Expected size 120-400 RTL lines total.

Verification
REQ-035 Reset, Start, 5 idle cycles -> PC 0,1,2,3,4,5; Running=1, Done=0.
REQ-036 PC=4, Br_rel, Offset=0xFB (-5) -> PC=4095; next cycle increment -> PC=0.
REQ-037 PC=10, Jump_abs, Link_en, Target=45 -> PC=45, link=11; later Ret -> PC=11.
REQ-038 PC=20, Stall+Jump_abs (Target=69) for 3 cycles -> PC stays 20; Stall released, Jump_abs -> PC=69.
REQ-039 PC=80, Halt+Jump_abs (Target=91) -> Done=1, PC=80 held 4 cycles; Start -> PC=0, Done=0.
REQ-040 Reset asserted in RUN at PC=91 with Jump_abs -> next cycle IDLE, PC=0, link=0, Running=0.
